// File: rtl/bcd_pkg.sv
// Purpose : shared types and constants for the double-dabble binary-to-BCD converter.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: FSM state encoding, add-3 constants, DIGITS/BIN_W legality function.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } dabble_state_t;

  // A BCD digit at or above this value would overflow past 9 when doubled,
  // so it is pre-corrected by this increment before the shift.
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_INC    = 4'd3;

  // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
  function automatic bit digits_ok(input int bin_w, input int digits);
    longint unsigned p10;
    longint unsigned vmax;
    p10 = 1;
    for (int i = 0; i < digits; i++) begin
      p10 = p10 * 10;
    end
    vmax = (64'd1 << bin_w) - 64'd1;
    return p10 > vmax;
  endfunction

endpackage

// File: rtl/dabble_ctrl_if.sv
// Purpose : start/done handshake and data bus of the binary-to-BCD converter.
// Latency : n/a (wiring only).
// Backpr. : start is accepted only while ready=1; otherwise it is dropped.
// Ports   : start, bin_in (requester -> converter); ready, busy, done, bcd_out (converter -> requester).
interface dabble_ctrl_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  // Requester side (upstream adder / testbench).
  modport master (
    output start,
    output bin_in,
    input  ready,
    input  busy,
    input  done,
    input  bcd_out
  );

  // Converter side.
  modport slave (
    input  start,
    input  bin_in,
    output ready,
    output busy,
    output done,
    output bcd_out
  );
endinterface

// File: rtl/dabble_add3.sv
// Purpose : one double-dabble digit correction cell (add 3 when digit >= 5).
// Latency : combinational.
// Backpr. : none.
// Ports   : din (4-bit BCD digit), dout (corrected digit, wraps mod 16).
module dabble_add3
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + ADD3_INC : din;

endmodule

// File: rtl/dabble_ctrl.sv
// Purpose : sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Latency : start accepted at edge N -> done pulse in the cycle after edge N+BIN_W.
// Backpr. : ready=1 only in IDLE/DONE; start while busy is ignored, never queued.
// Ports   : clk, rst (async, active high); bus = dabble_ctrl_if.slave
//           (start, bin_in, ready, busy, done, bcd_out).
module dabble_ctrl
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  dabble_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;

  if (!digits_ok(BIN_W, DIGITS)) begin : g_bad_params
    $error("dabble_ctrl: DIGITS too small to represent 2^BIN_W-1");
  end

  dabble_state_t     state_q, state_d;
  logic [SR_W-1:0]   sr_q;      // {bcd digits, binary operand}
  logic [SR_W-1:0]   sr_adj;    // sr_q after per-digit add-3 correction
  logic [SR_W-1:0]   sr_shift;  // corrected register shifted left by one
  logic [CNT_W-1:0]  cnt_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              busy_q;
  logic              done_q;
  logic              ready;
  logic              accept;
  logic              last_shift;

  assign ready      = (state_q == IDLE) || (state_q == DONE);
  assign accept     = bus.start && ready;
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

  // Correction is applied to every digit before the shift on each iteration.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    dabble_add3 u_add3 (
      .din  (sr_q[BIN_W+4*i +: 4]),
      .dout (sr_adj[BIN_W+4*i +: 4])
    );
  end
  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
  assign sr_shift          = {sr_adj[SR_W-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
    end else if (accept) begin
      sr_q  <= {{BCD_W{1'b0}}, bus.bin_in};
      cnt_q <= CNT_W'(BIN_W);
    end else if (state_q == SHIFT) begin
      sr_q  <= sr_shift;
      cnt_q <= cnt_q - CNT_W'(1);
      // Result is published only here, so bcd_out holds across a new conversion.
      if (last_shift) bcd_q <= sr_shift[SR_W-1:BIN_W];
    end
  end

  assign bus.ready   = ready;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_dabble_ctrl.sv
// Purpose : directed self-checking bench for dabble_ctrl (BIN_W=8, DIGITS=3).
// Latency : checks done exactly BIN_W edges after the accepting edge.
// Backpr. : checks start is ignored while busy and accepted back-to-back in DONE.
module tb_dabble_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dabble_ctrl_if #(.BIN_W(8), .DIGITS(3)) bus ();

  dabble_ctrl #(.BIN_W(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = 8'd0;
    #2;
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 12'h000) begin
      failures++;
      $display("FAIL reset: ready=%b busy=%b done=%b bcd=%h, want 1 0 0 000",
               bus.ready, bus.busy, bus.done, bus.bcd_out);
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: ready=%b busy=%b done=%b, want 1 0 0",
               bus.ready, bus.busy, bus.done);
    end
  endtask

  // One full conversion; optionally scrambles bin_in during SHIFT.
  task automatic run_conv(input string name, input logic [7:0] v,
                          input logic [11:0] want, input logic [11:0] prev,
                          input bit scramble);
    bit shift_ok;
    bus.start  = 1'b1;
    bus.bin_in = v;
    step();                        // accepting edge
    bus.start  = 1'b0;
    shift_ok   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.ready !== 1'b0 || bus.bcd_out !== prev) begin
        shift_ok = 1'b0;
        $display("FAIL %s_shift_cyc%0d: busy=%b done=%b ready=%b bcd=%h, want 1 0 0 %h",
                 name, i, bus.busy, bus.done, bus.ready, bus.bcd_out, prev);
      end
      if (scramble) bus.bin_in = 8'($urandom);
      step();
    end
    checks++;
    if (!shift_ok) failures++;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.bcd_out !== want) begin
      failures++;
      $display("FAIL %s_done: done=%b busy=%b ready=%b bcd=%h, want 1 0 1 %h",
               name, bus.done, bus.busy, bus.ready, bus.bcd_out, want);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.bcd_out !== want) begin
      failures++;
      $display("FAIL %s_after_done: done=%b busy=%b bcd=%h, want 0 0 %h",
               name, bus.done, bus.busy, bus.bcd_out, want);
    end
  endtask

  task automatic test_basic();
    run_conv("conv255", 8'd255, 12'h255, 12'h000, 1'b0);
    run_conv("conv0",   8'd0,   12'h000, 12'h255, 1'b0);
    run_conv("conv99",  8'd99,  12'h099, 12'h000, 1'b0);
    run_conv("conv9",   8'd9,   12'h009, 12'h099, 1'b0);
  endtask

  task automatic test_back_to_back();
    bus.start  = 1'b1;
    bus.bin_in = 8'd128;
    step();
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (bus.done !== 1'b1 || bus.bcd_out !== 12'h128) begin
      failures++;
      $display("FAIL b2b_first: done=%b bcd=%h, want 1 128", bus.done, bus.bcd_out);
    end
    bus.bin_in = 8'd200;           // presented on the done cycle, start still high
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_gap: busy=%b done=%b, want 1 0", bus.busy, bus.done);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (bus.done !== 1'b1 || bus.bcd_out !== 12'h200) begin
      failures++;
      $display("FAIL b2b_second: done=%b bcd=%h, want 1 200", bus.done, bus.bcd_out);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int extra_done;
    bus.start  = 1'b1;
    bus.bin_in = 8'd37;
    step();
    bus.start = 1'b0;
    step();                        // SHIFT cycle 2
    bus.start  = 1'b1;             // pulsed for SHIFT cycle 3
    bus.bin_in = 8'd250;
    step();
    bus.start  = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (bus.done !== 1'b1 || bus.bcd_out !== 12'h037) begin
      failures++;
      $display("FAIL ignore_start_done: done=%b bcd=%h, want 1 037", bus.done, bus.bcd_out);
    end
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0 || bus.bcd_out !== 12'h037) begin
      failures++;
      $display("FAIL ignore_start_extra: extra_done=%0d bcd=%h, want 0 037", extra_done, bus.bcd_out);
    end
  endtask

  task automatic test_reset_mid();
    int late_done;
    bus.start  = 1'b1;
    bus.bin_in = 8'd180;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) step();   // now in SHIFT cycle 4
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 12'h000 || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b ready=%b bcd=%h, want 0 0 1 000",
               bus.busy, bus.done, bus.ready, bus.bcd_out);
    end
    #2;
    rst = 1'b0;
    late_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) late_done++;
    end
    checks++;
    if (late_done != 0 || bus.bcd_out !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid_after: stray_cycles=%0d bcd=%h, want 0 000", late_done, bus.bcd_out);
    end
    run_conv("post_reset5", 8'd5, 12'h005, 12'h000, 1'b0);
  endtask

  task automatic test_bin_change();
    run_conv("bin_change64", 8'd64, 12'h064, 12'h005, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_bin_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dabble_ctrl.md
Name: dabble_ctrl

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 ("double dabble") algorithm.
- Holds the shift register, iteration counter and FSM, and reuses one combinational add-3 digit cell per BCD digit on every iteration.
- Sits between the binary result of the ASCII adder and the ASCII/display encoding stage.
- Uses a start/done handshake so the downstream encoder can sample a stable BCD word.

Parameters:
- BIN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; an elaboration-time check fails otherwise.
- CNT_W, $clog2(BIN_W+1), iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a conversion. Sampled on a rising clk edge when ready=1.
- bin_in  in  BIN_W  binary operand. Captured in the same cycle start is accepted.
- ready  out  1  block can accept start (state IDLE or DONE). Combinational from state.
- busy  out  1  conversion in progress (state SHIFT). Registered.
- done  out  1  one-cycle pulse; bcd_out is valid from this cycle.
- bcd_out  out  4*DIGITS  packed BCD result, digit 0 in [3:0]. Held until the next accepted start.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, busy=0, done=0, bcd_out=0, shift register=0, counter=0. Therefore ready=1.
- Shift register: {bcd digits (4*DIGITS), binary (BIN_W)}, total 4*DIGITS+BIN_W bits.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> load bin_in into the binary field, clear the BCD field, counter=BIN_W, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - Each digit d_i is replaced by add3(d_i).
  - The whole register is then shifted left by 1; the MSB of the binary field enters bit 0 of digit 0.
  - counter decrements by 1.
  - When counter==1 at this edge: the post-shift BCD field is written into bcd_out, and the state goes to DONE.
- add3 rule: out = in+3 (mod 16) if in >= 5, else out = in. Inputs 10..15 cannot occur when the DIGITS constraint holds; they wrap mod 16 and are not checked.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - start=1 while in DONE is accepted exactly as in IDLE (load, then SHIFT), which allows back-to-back conversions.
- Latency: start accepted at edge N -> busy=1 for edges N+1..N+BIN_W -> done=1 during the cycle after edge N+BIN_W. With BIN_W=8, done appears 9 cycles after the accepting edge.
- Throughput: one result every BIN_W+1 cycles with start held high.
- start while busy=1 is ignored: no effect on the conversion, no queuing.
- bin_in changes during SHIFT have no effect; the operand is captured only at acceptance.
- bcd_out changes only on the SHIFT->DONE edge or on reset. It holds its previous value throughout a new conversion.
- Reset mid-conversion: immediate return to the reset values listed above. The partial result is discarded and done is not asserted.
- bin_in=0: normal full BIN_W iterations; result 0.

Decomposition:
- Shared package bcd_pkg:
  - state encoding typedef (IDLE/SHIFT/DONE);
  - localparam ADD3_THRESH=5 and ADD3_INC=3;
  - function for the DIGITS/BIN_W legality check.
- Sub-module dabble_add3 (4-bit in, 4-bit out, combinational), instantiated DIGITS times via generate.
- The FSM, counter and shift register stay in dabble_ctrl.

Test Plan:
- Reset, then bin_in=8'd255, start pulse -> busy high for 8 cycles; done pulse on the 9th cycle; bcd_out=12'h255; ready=1 during done.
- bin_in=8'd0 -> bcd_out=12'h000 after 9 cycles. Then bin_in=8'd99 -> 12'h099. Then 8'd9 -> 12'h009 (the digit stays below the add-3 threshold on every iteration).
- start held high with bin_in=8'd128, then 8'd200 presented on the done cycle -> 12'h128 at the first done and 12'h200 exactly 9 cycles later, with no idle gap.
- Conversion of 8'd37 running; at cycle 3 of SHIFT pulse start with bin_in=8'd250 -> ignored; result 12'h037; no extra done.
- Conversion of 8'd180 running; assert rst at SHIFT cycle 4 -> busy=0, done=0, bcd_out=0 asynchronously; no done after rst releases; the next start of 8'd5 gives 12'h005.
- Change bin_in every cycle during SHIFT after accepting 8'd64 -> bcd_out=12'h064. The previous bcd_out value holds stable until the done cycle.
